// File: rtl/ysyx_24090012_lsu_pkg.sv
// Shared LSU definitions: FSM encoding, RV32 load/store opcodes, funct3 codes
// and the request decoder used when a new EXU request is accepted.
package ysyx_24090012_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic is_mem;    // legal, aligned load/store: goes to the bus
        logic is_store;  // legal, aligned store
        logic err;       // load/store opcode that must be rejected
    } lsu_decode_t;

    function automatic lsu_decode_t lsu_decode(input logic [31:0] inst,
                                               input logic [1:0]  addr_lo);
        lsu_decode_t d;
        logic [2:0]  f3;
        logic        is_load_op;
        logic        is_store_op;
        logic        legal;
        logic        aligned;
        d           = '0;
        f3          = inst[14:12];
        is_load_op  = (inst[6:0] == OPC_LOAD);
        is_store_op = (inst[6:0] == OPC_STORE);
        legal       = 1'b0;
        aligned     = 1'b0;
        if (is_load_op)
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        else if (is_store_op)
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        case (f3)
            F3_B, F3_BU: aligned = 1'b1;
            F3_H, F3_HU: aligned = ~addr_lo[0];
            F3_W:        aligned = (addr_lo == 2'b00);
            default:     aligned = 1'b0;
        endcase
        d.is_mem   = (is_load_op || is_store_op) && legal && aligned;
        d.is_store = is_store_op && legal && aligned;
        d.err      = (is_load_op || is_store_op) && !(legal && aligned);
        return d;
    endfunction

endpackage

// File: rtl/ysyx_24090012_lsu_align.sv
// Byte-lane alignment: store mask and data shift toward the bus, and load
// extraction plus sign/zero extension from the bus read word.
module ysyx_24090012_lsu_align
    import ysyx_24090012_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [4:0]  shamt;
    logic [31:0] raw;

    assign shamt      = {addr_lo, 3'b000};
    assign wdata_lane = wdata << shamt;
    assign raw        = rdata >> shamt;

    always_comb begin
        wmask = 4'b0000;
        if (is_store) begin
            case (funct3)
                F3_B:    wmask = 4'b0001 << addr_lo;
                F3_H:    wmask = 4'b0011 << addr_lo;
                F3_W:    wmask = 4'b1111;
                default: wmask = 4'b0000;
            endcase
        end
    end

    always_comb begin
        load_data = 32'h0;
        case (funct3)
            F3_B:    load_data = {{24{raw[7]}}, raw[7:0]};
            F3_H:    load_data = {{16{raw[15]}}, raw[15:0]};
            F3_W:    load_data = raw;
            F3_BU:   load_data = {24'h0, raw[7:0]};
            F3_HU:   load_data = {16'h0, raw[15:0]};
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/ysyx_24090012_lsu.sv
// Load/store unit: accepts one EXU request, runs a single request/response
// bus transaction for legal accesses, and returns a one-cycle completion pulse.
module ysyx_24090012_lsu
    import ysyx_24090012_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] exu_to_lsu_inst,
    output logic        mem_ready,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic [31:0] lsu_inst,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_wen,
    output logic [3:0]  bus_wmask,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    output logic        bus_rsp_ready,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rsp_err
);

    lsu_state_t  state_reg;
    lsu_state_t  state_next;
    lsu_decode_t dec;

    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] inst_reg;
    logic        is_store_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic [31:0] load_data;
    logic        accept;
    logic        rsp_take;

    assign dec      = lsu_decode(exu_to_lsu_inst, mem_addr[1:0]);
    assign accept   = (state_reg == ST_IDLE) && mem_valid;
    assign rsp_take = (state_reg == ST_RSP) && bus_rsp_valid;

    ysyx_24090012_lsu_align u_align (
        .funct3     (inst_reg[14:12]),
        .is_store   (is_store_reg),
        .addr_lo    (addr_reg[1:0]),
        .wdata      (wdata_reg),
        .rdata      (bus_rdata),
        .wmask      (bus_wmask),
        .wdata_lane (bus_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        mem_ready     = 1'b0;
        bus_req_valid = 1'b0;
        bus_rsp_ready = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (mem_valid)
                    state_next = dec.is_mem ? ST_REQ : ST_DONE;
            end
            ST_REQ: begin
                bus_req_valid = 1'b1;
                if (bus_req_ready)
                    state_next = ST_RSP;
            end
            // Response only looked at here, so one arriving alongside request
            // acceptance is left on the bus.
            ST_RSP: begin
                bus_rsp_ready = 1'b1;
                if (bus_rsp_valid)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                mem_ready  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_reg     <= 32'h0;
            wdata_reg    <= 32'h0;
            inst_reg     <= 32'h0;
            is_store_reg <= 1'b0;
            rdata_reg    <= 32'h0;
            err_reg      <= 1'b0;
        end else if (accept) begin
            addr_reg     <= mem_addr;
            wdata_reg    <= mem_wdata;
            inst_reg     <= exu_to_lsu_inst;
            is_store_reg <= dec.is_store;
            rdata_reg    <= 32'h0;
            err_reg      <= dec.err;
        end else if (rsp_take) begin
            rdata_reg    <= (bus_rsp_err || is_store_reg) ? 32'h0 : load_data;
            err_reg      <= bus_rsp_err;
        end
    end

    assign bus_addr  = {addr_reg[31:2], 2'b00};
    assign bus_wen   = is_store_reg;
    assign lsu_rdata = rdata_reg;
    assign lsu_err   = err_reg;
    assign lsu_inst  = inst_reg;

endmodule

// File: tb/tb_ysyx_24090012_lsu.sv
// Directed bench for the LSU: loads, stores, alignment errors, bus stalls,
// bus errors, reset abort and back-to-back requests.
module tb_ysyx_24090012_lsu;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] exu_to_lsu_inst;
    logic        mem_ready;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic [31:0] lsu_inst;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_wen;
    logic [3:0]  bus_wmask;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic        bus_rsp_ready;
    logic [31:0] bus_rdata;
    logic        bus_rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_24090012_lsu dut (
        .clk             (clk),
        .rst             (rst),
        .mem_valid       (mem_valid),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .exu_to_lsu_inst (exu_to_lsu_inst),
        .mem_ready       (mem_ready),
        .lsu_rdata       (lsu_rdata),
        .lsu_err         (lsu_err),
        .lsu_inst        (lsu_inst),
        .bus_req_valid   (bus_req_valid),
        .bus_req_ready   (bus_req_ready),
        .bus_addr        (bus_addr),
        .bus_wen         (bus_wen),
        .bus_wmask       (bus_wmask),
        .bus_wdata       (bus_wdata),
        .bus_rsp_valid   (bus_rsp_valid),
        .bus_rsp_ready   (bus_rsp_ready),
        .bus_rdata       (bus_rdata),
        .bus_rsp_err     (bus_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h required %08h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [6:0] opc);
        return {12'h000, 5'd2, f3, 5'd1, opc};
    endfunction

    // Present a request for exactly one edge; returns just after the accepting edge.
    task automatic start_req(input logic [31:0] inst, input logic [31:0] addr,
                             input logic [31:0] wdata);
        mem_valid       = 1'b1;
        exu_to_lsu_inst = inst;
        mem_addr        = addr;
        mem_wdata       = wdata;
        tick();
        mem_valid       = 1'b0;
    endtask

    // Latency counts edges from the accepting edge to the one sampling mem_ready.
    task automatic wait_done(input string tag, output int lat);
        lat = 1;
        while (!mem_ready && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, ".done"}, 32'(mem_ready), 32'd1);
    endtask

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    int lat;

    initial begin
        rst = 1'b0;
        mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; exu_to_lsu_inst = '0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0; bus_rsp_err = 1'b0;
        tick(); tick();
        check("rst.mem_ready", 32'(mem_ready), 32'd0);
        check("rst.req_valid", 32'(bus_req_valid), 32'd0);
        check("rst.rsp_ready", 32'(bus_rsp_ready), 32'd0);
        check("rst.err", 32'(lsu_err), 32'd0);
        check("rst.rdata", lsu_rdata, 32'h0);
        check("rst.inst", lsu_inst, 32'h0);
        rst = 1'b1;
        tick();

        // LW aligned, bus always ready with an immediate response
        bus_req_ready = 1'b1; bus_rsp_valid = 1'b1; bus_rdata = 32'hDEADBEEF;
        start_req(mk_inst(3'b010, LOAD), 32'h80000004, 32'h0);
        check("lw.req_valid", 32'(bus_req_valid), 32'd1);
        check("lw.rsp_ready_in_req", 32'(bus_rsp_ready), 32'd0);
        check("lw.bus_addr", bus_addr, 32'h80000004);
        check("lw.wen", 32'(bus_wen), 32'd0);
        check("lw.wmask", 32'(bus_wmask), 32'h0);
        wait_done("lw", lat);
        check("lw.latency", 32'(lat), 32'd3);
        check("lw.rdata", lsu_rdata, 32'hDEADBEEF);
        check("lw.err", 32'(lsu_err), 32'd0);
        check("lw.inst", lsu_inst, mk_inst(3'b010, LOAD));
        tick();
        check("lw.pulse_end", 32'(mem_ready), 32'd0);

        // LB / LBU at byte 3
        bus_rdata = 32'h80FF0102;
        start_req(mk_inst(3'b000, LOAD), 32'h80000003, 32'h0);
        check("lb.bus_addr", bus_addr, 32'h80000000);
        wait_done("lb", lat);
        check("lb.rdata", lsu_rdata, 32'hFFFFFF80);
        tick();
        start_req(mk_inst(3'b100, LOAD), 32'h80000003, 32'h0);
        wait_done("lbu", lat);
        check("lbu.rdata", lsu_rdata, 32'h00000080);
        tick();

        // LHU at upper half, LH at lower half
        start_req(mk_inst(3'b101, LOAD), 32'h80000002, 32'h0);
        wait_done("lhu", lat);
        check("lhu.rdata", lsu_rdata, 32'h000080FF);
        tick();
        bus_rdata = 32'h12348001;
        start_req(mk_inst(3'b001, LOAD), 32'h80000000, 32'h0);
        wait_done("lh", lat);
        check("lh.rdata", lsu_rdata, 32'hFFFF8001);
        tick();

        // SH at upper half
        start_req(mk_inst(3'b001, STORE), 32'h80000002, 32'h1234ABCD);
        check("sh.wen", 32'(bus_wen), 32'd1);
        check("sh.wmask", 32'(bus_wmask), 32'hC);
        check("sh.wdata", bus_wdata, 32'hABCD0000);
        check("sh.bus_addr", bus_addr, 32'h80000000);
        wait_done("sh", lat);
        check("sh.rdata", lsu_rdata, 32'h0);
        check("sh.err", 32'(lsu_err), 32'd0);
        tick();

        // SB at byte 1
        start_req(mk_inst(3'b000, STORE), 32'h80000001, 32'h000000A5);
        check("sb.wmask", 32'(bus_wmask), 32'h2);
        check("sb.wdata", bus_wdata, 32'h0000A500);
        wait_done("sb", lat);
        tick();

        // Misaligned LW: no bus traffic, completes one cycle after accept
        start_req(mk_inst(3'b010, LOAD), 32'h80000002, 32'h0);
        check("lw_mis.req_valid", 32'(bus_req_valid), 32'd0);
        wait_done("lw_mis", lat);
        check("lw_mis.latency", 32'(lat), 32'd1);
        check("lw_mis.err", 32'(lsu_err), 32'd1);
        check("lw_mis.rdata", lsu_rdata, 32'h0);
        tick();

        // Misaligned LH and illegal load funct3
        start_req(mk_inst(3'b001, LOAD), 32'h80000001, 32'h0);
        check("lh_mis.req_valid", 32'(bus_req_valid), 32'd0);
        wait_done("lh_mis", lat);
        check("lh_mis.err", 32'(lsu_err), 32'd1);
        tick();
        start_req(mk_inst(3'b011, LOAD), 32'h80000000, 32'h0);
        wait_done("ld_f3", lat);
        check("ld_f3.err", 32'(lsu_err), 32'd1);
        tick();

        // Non-memory op completes without error
        start_req(32'h00208033, 32'h80000000, 32'h0);
        check("alu.req_valid", 32'(bus_req_valid), 32'd0);
        wait_done("alu", lat);
        check("alu.latency", 32'(lat), 32'd1);
        check("alu.err", 32'(lsu_err), 32'd0);
        check("alu.inst", lsu_inst, 32'h00208033);
        tick();

        // SW stalled in REQ for 5 cycles, then bus error
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        start_req(mk_inst(3'b010, STORE), 32'h80000008, 32'h11223344);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("sw_stall%0d.req_valid", i), 32'(bus_req_valid), 32'd1);
            check($sformatf("sw_stall%0d.addr", i), bus_addr, 32'h80000008);
            check($sformatf("sw_stall%0d.wmask", i), 32'({bus_wen, bus_wmask}), 32'h1F);
            check($sformatf("sw_stall%0d.wdata", i), bus_wdata, 32'h11223344);
            tick();
        end
        bus_req_ready = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_err = 1'b1;
        wait_done("sw_err", lat);
        check("sw_err.err", 32'(lsu_err), 32'd1);
        check("sw_err.rdata", lsu_rdata, 32'h0);
        bus_rsp_err = 1'b0;
        tick();

        // Reset while waiting in RSP; the late response must be ignored
        bus_rsp_valid = 1'b0; bus_rdata = 32'hCAFEF00D;
        start_req(mk_inst(3'b010, LOAD), 32'h80000010, 32'h0);
        tick();
        check("rstmid.rsp_ready", 32'(bus_rsp_ready), 32'd1);
        rst = 1'b0; bus_rsp_valid = 1'b1;
        tick();
        check("rstmid.mem_ready", 32'(mem_ready), 32'd0);
        check("rstmid.req_valid", 32'(bus_req_valid), 32'd0);
        check("rstmid.rsp_ready", 32'(bus_rsp_ready), 32'd0);
        check("rstmid.err", 32'(lsu_err), 32'd0);
        check("rstmid.rdata", lsu_rdata, 32'h0);
        check("rstmid.inst", lsu_inst, 32'h0);
        check("rstmid.bus", bus_addr | bus_wdata | 32'({bus_wen, bus_wmask}), 32'h0);
        rst = 1'b1;
        tick();
        check("rstmid.late_rsp", 32'(mem_ready), 32'd0);
        bus_rsp_valid = 1'b0;
        tick();

        // Back-to-back: mem_valid held; DONE ignores it, next IDLE accepts
        mem_valid = 1'b1; exu_to_lsu_inst = 32'h00208033; mem_addr = 32'h0;
        tick();
        check("b2b.first", 32'(mem_ready), 32'd1);
        exu_to_lsu_inst = 32'h40208033;
        tick();
        check("b2b.gap", 32'(mem_ready), 32'd0);
        check("b2b.inst_held", lsu_inst, 32'h00208033);
        tick();
        mem_valid = 1'b0;
        check("b2b.second", 32'(mem_ready), 32'd1);
        check("b2b.inst_new", lsu_inst, 32'h40208033);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
